// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: program counter, IF/ID pipeline register, stall and branch redirect.
// Define IFETCH_PERF_EN to add the FetchCount / BubbleCount performance counters.
module instruction_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        CLK,
   input  logic        Reset,
   output logic [63:0] InstrAddr,
   input  logic [31:0] InstrData,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [63:0] BranchTarget,
   output logic [31:0] IfId_Instr,
   output logic [63:0] IfId_PC,
   output logic        IfId_Valid,
   output logic        Misaligned
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] FetchCount,
   output logic [31:0] BubbleCount
`endif
);

   // state | meaning
   // BOOT  | first cycle after reset, nothing captured, PC held
   // RUN   | fetching; priority BranchTaken > Stall > normal
   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      r_state;
   logic [63:0] r_pc;
   logic [31:0] r_instr;
   logic [63:0] r_ifpc;
   logic        r_valid;
   logic        r_mis;
`ifdef IFETCH_PERF_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_bubble_cnt;
`endif

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= BOOT;
         r_pc    <= RESET_PC;
         r_instr <= 32'h0;
         r_ifpc  <= 64'h0;
         r_valid <= 1'b0;
         r_mis   <= 1'b0;
`ifdef IFETCH_PERF_EN
         r_fetch_cnt  <= 32'h0;
         r_bubble_cnt <= 32'h0;
`endif
      end else begin
         r_mis <= 1'b0;
         case (r_state)
            BOOT: r_state <= RUN;
            RUN: begin
               if (BranchTaken) begin
                  // redirect flushes the wrong-path fetch but keeps the old IF/ID contents
                  r_pc    <= {BranchTarget[63:2], 2'b00};
                  r_valid <= 1'b0;
                  r_mis   <= |BranchTarget[1:0];
               end else if (!Stall) begin
                  r_instr <= InstrData;
                  r_ifpc  <= r_pc;
                  r_valid <= 1'b1;
                  r_pc    <= r_pc + 64'd4;
               end
`ifdef IFETCH_PERF_EN
               if (BranchTaken || Stall)
                  r_bubble_cnt <= r_bubble_cnt + 32'd1;
               else
                  r_fetch_cnt <= r_fetch_cnt + 32'd1;
`endif
            end
            default: r_state <= BOOT;
         endcase
      end
   end

   assign InstrAddr  = r_pc;
   assign IfId_Instr = r_instr;
   assign IfId_PC    = r_ifpc;
   assign IfId_Valid = r_valid;
   assign Misaligned = r_mis;
`ifdef IFETCH_PERF_EN
   assign FetchCount  = r_fetch_cnt;
   assign BubbleCount = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed program, stall/branch/reset cases, random run.
// Counter checks are compiled in when IFETCH_PERF_EN is defined.
module tb_instruction_fetch;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [63:0] InstrAddr;
   logic [31:0] InstrData;
   logic        Stall;
   logic        BranchTaken;
   logic [63:0] BranchTarget;
   logic [31:0] IfId_Instr;
   logic [63:0] IfId_PC;
   logic        IfId_Valid;
   logic        Misaligned;
`ifdef IFETCH_PERF_EN
   logic [31:0] FetchCount;
   logic [31:0] BubbleCount;
`endif

   logic [31:0] mem [0:63];

   int tests = 0;
   int fails = 0;

   // reference state, updated from the behavioural rules once per edge
   logic [63:0] m_pc;
   logic [31:0] m_instr;
   logic [63:0] m_ifpc;
   logic        m_valid;
   logic        m_mis;
   logic        m_boot;
   logic [31:0] m_fetch;
   logic [31:0] m_bubble;

   instruction_fetch #(.RESET_PC(64'h0)) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .InstrAddr   (InstrAddr),
      .InstrData   (InstrData),
      .Stall       (Stall),
      .BranchTaken (BranchTaken),
      .BranchTarget(BranchTarget),
      .IfId_Instr  (IfId_Instr),
      .IfId_PC     (IfId_PC),
      .IfId_Valid  (IfId_Valid),
      .Misaligned  (Misaligned)
`ifdef IFETCH_PERF_EN
      ,
      .FetchCount  (FetchCount),
      .BubbleCount (BubbleCount)
`endif
   );

   always #5 CLK = ~CLK;

   assign InstrData = mem[InstrAddr[7:2]];

   function automatic logic [31:0] mem_at(input logic [63:0] a);
      logic [5:0] idx;
      idx = a[7:2];
      return mem[idx];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("InstrAddr", InstrAddr, m_pc);
      chk("IfId_Instr", {32'h0, IfId_Instr}, {32'h0, m_instr});
      chk("IfId_PC", IfId_PC, m_ifpc);
      chk("IfId_Valid", {63'h0, IfId_Valid}, {63'h0, m_valid});
      chk("Misaligned", {63'h0, Misaligned}, {63'h0, m_mis});
`ifdef IFETCH_PERF_EN
      chk("FetchCount", {32'h0, FetchCount}, {32'h0, m_fetch});
      chk("BubbleCount", {32'h0, BubbleCount}, {32'h0, m_bubble});
`endif
   endtask

   // one clock edge with the given inputs; model advances, then outputs compared
   task automatic step(input logic rst, input logic stl, input logic br, input logic [63:0] tgt);
      Reset        = rst;
      Stall        = stl;
      BranchTaken  = br;
      BranchTarget = tgt;
      @(posedge CLK);
      if (rst) begin
         m_pc = 64'h0; m_instr = 32'h0; m_ifpc = 64'h0; m_valid = 1'b0;
         m_mis = 1'b0; m_boot = 1'b1; m_fetch = 32'h0; m_bubble = 32'h0;
      end else if (m_boot) begin
         m_boot = 1'b0;
         m_mis  = 1'b0;
      end else if (br) begin
         m_bubble = m_bubble + 1;
         m_mis    = (tgt % 4) != 0;
         m_pc     = tgt - (tgt % 4);
         m_valid  = 1'b0;
      end else if (stl) begin
         m_bubble = m_bubble + 1;
         m_mis    = 1'b0;
      end else begin
         m_fetch = m_fetch + 1;
         m_instr = mem_at(m_pc);
         m_ifpc  = m_pc;
         m_valid = 1'b1;
         m_pc    = m_pc + 64'd4;
         m_mis   = 1'b0;
      end
      #1;
      check_all();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h910003E1;
      mem[1] = 32'h910007E2;
      mem[2] = 32'h910003E3;
      mem[3] = 32'h8B020021;
      mem[4] = 32'h8B030042;
      mem[5] = 32'hB4000061;
      m_boot = 1'b1;

      // reset, BOOT edge, then straight-line program
      step(1, 0, 0, 64'h0);
      step(1, 0, 0, 64'h0);
      step(0, 1, 1, 64'h40);           // BOOT: branch/stall ignored
      step(0, 0, 0, 64'h0);
      chk("first_instr", {32'h0, IfId_Instr}, 64'h910003E1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 64'h0);
      chk("cbz_captured", IfId_PC, 64'h14);

      // CBZ redirect to 0x004: one bubble, then target
      step(0, 0, 1, 64'h4);
      chk("bubble", {63'h0, IfId_Valid}, 64'h0);
      step(0, 0, 0, 64'h0);
      chk("target_instr", {32'h0, IfId_Instr}, 64'h910007E2);

      // stall three cycles at PC=0x008
      for (int i = 0; i < 3; i++) step(0, 1, 0, 64'h0);
      chk("stall_addr", InstrAddr, 64'h8);
      step(0, 0, 0, 64'h0);
      chk("after_stall", IfId_PC, 64'h8);

      // stall with misaligned branch to 0x00E
      step(0, 1, 1, 64'hE);
      chk("mis_pc", InstrAddr, 64'hC);
      chk("mis_flag", {63'h0, Misaligned}, 64'h1);
      step(0, 0, 0, 64'h0);
      chk("mis_pulse", {63'h0, Misaligned}, 64'h0);

      // reset during stall at PC=0x010
      step(0, 1, 0, 64'h0);
      step(1, 1, 0, 64'h0);
      step(0, 0, 0, 64'h0);
      step(0, 0, 0, 64'h0);
      step(0, 0, 0, 64'h0);

      // reset coincident with branch: redirect lost
      step(1, 0, 1, 64'h80);
      chk("rst_beats_br", InstrAddr, 64'h0);
      step(0, 0, 0, 64'h0);
      step(0, 0, 0, 64'h0);

      // PC wrap at top of address space
      step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      step(0, 0, 0, 64'h0);
      chk("wrap", InstrAddr, 64'h0);
      step(0, 0, 0, 64'h0);

      // randomized run
      for (int i = 0; i < 400; i++) begin
         logic [63:0] t;
         t = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 0) t = {56'h0, t[7:0]};
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 6) == 0), t);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the LEGv8 pipeline, directly upstream of the instruction memory and feeding the decode stage. Holds the program counter, drives the 64-bit fetch address, captures the returned 32-bit instruction into the IF/ID pipeline register, and handles stall and branch-redirect requests from downstream. Memory read is combinational: the address issued in cycle N is captured at the end of cycle N.

## Interface
- `RESET_PC`, 64'h0, PC loaded on reset; must be word-aligned.
- `CLK` input 1: single clock, all state updates on rising edge.
- `Reset` input 1: synchronous, active-high.
- `InstrAddr` output 64: fetch address to instruction memory; equals current PC.
- `InstrData` input 32: instruction returned by memory for `InstrAddr`.
- `Stall` input 1: hazard unit hold request; freezes PC and IF/ID.
- `BranchTaken` input 1: decode/execute redirect request, single-cycle pulse.
- `BranchTarget` input 64: redirect address, sampled when `BranchTaken`=1.
- `IfId_Instr` output 32: registered instruction to decode.
- `IfId_PC` output 64: registered PC of `IfId_Instr`.
- `IfId_Valid` output 1: `IfId_Instr` is a real instruction (0 = bubble).
- `Misaligned` output 1: registered, pulses one cycle when a redirect target had nonzero bits [1:0].

## Operation
- FSM states: BOOT, RUN.
  - Reset (any state) -> BOOT. BOOT lasts one cycle: no capture, `IfId_Valid` stays 0, PC unchanged.
  - BOOT -> RUN unconditionally (unless `Reset`). RUN stays RUN until `Reset`.
- Per-edge priority in RUN: `Reset` > `BranchTaken` > `Stall` > normal.
  - Normal: `IfId_Instr`<=`InstrData`, `IfId_PC`<=PC, `IfId_Valid`<=1, PC<=PC+4.
  - Stall (no branch): PC, `IfId_*` all hold.
  - BranchTaken (with or without Stall): PC<={BranchTarget[63:2],2'b00}, `IfId_Valid`<=0 (flush the wrong-path fetch), `IfId_Instr`/`IfId_PC` hold; `Misaligned`<=|BranchTarget[1:0].
- `BranchTaken`/`Stall` in BOOT are ignored.
- PC arithmetic: 64-bit unsigned, PC+4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0 silently.
- `Misaligned` is 0 in every cycle not following a misaligned redirect.

## Timing
- Reset values: PC=`RESET_PC`, `InstrAddr`=`RESET_PC`, `IfId_Instr`=32'h0, `IfId_PC`=64'h0, `IfId_Valid`=0, `Misaligned`=0, state=BOOT.
- Fetch latency: instruction at address A appears on `IfId_Instr` one edge after `InstrAddr`=A (no stall).
- First valid instruction: edge 2 after `Reset` deasserts (edge 1 = BOOT->RUN).
- Taken branch costs exactly one bubble: edge k flushes; edge k+1 captures target instruction with `IfId_Valid`=1 (if not stalled).
- Reset asserted mid-stall or coincident with `BranchTaken`: reset wins, redirect lost.
- `InstrAddr` changes only on clock edges; memory read time must be < clock period.

## Configuration
- `IFETCH_PERF_EN` defined: adds outputs `FetchCount` [31:0] (increments on every edge capturing `IfId_Valid`<=1) and `BubbleCount` [31:0] (increments on every RUN edge with Stall or BranchTaken); both reset to 0, wrap at 2^32, hold during BOOT.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset then run over program at 0x000..0x010 -> `IfId_Valid` 0 on edge 1, then `IfId_Instr` = 32'h910003E1, 32'h910007E2, 32'h910003E3, 32'h8B020021 with `IfId_PC` 0x000, 0x004, 0x008, 0x00C on edges 2-5.
- CBZ at 0x014 with `BranchTaken`=1, `BranchTarget`=0x004 on the edge after it is captured -> one bubble (`IfId_Valid`=0), next capture `IfId_PC`=0x004, `IfId_Instr`=32'h910007E2.
- `Stall`=1 for 3 cycles at PC=0x008 -> `InstrAddr` and `IfId_*` constant 3 cycles; release -> 0x008 instruction captured, no skip or duplicate.
- `Stall` and `BranchTaken` together, target 0x00E -> PC=0x00C, `Misaligned`=1 for one cycle, `IfId_Valid`=0.
- `Reset` asserted during stall at PC=0x010 -> next edge PC=0, `IfId_Valid`=0, state BOOT; normal fetch resumes.
- With `IFETCH_PERF_EN`: 5 valid fetches, 2 stall cycles, 1 branch -> `FetchCount`=5, `BubbleCount`=3.
